// File: rtl/rosc_sched_pkg.sv
// Shared definitions for the ring-oscillator measurement scheduler.
package rosc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ARM,
        WAIT,
        CAPTURE,
        RELEASE,
        DONE
    } sched_state_t;

    // Sensor operating modes as seen on RoscMode
    localparam logic [1:0] ROSC_STOP = 2'b00;
    localparam logic [1:0] ROSC_FAST = 2'b01;
    localparam logic [1:0] ROSC_SLOW = 2'b10;

    // Extra cycles tolerated beyond the measurement window before timeout
    localparam int TIMEOUT_MARGIN_DEFAULT = 8;

endpackage

// File: rtl/rosc_result_bank.sv
// Result register file: one reading per sensor plus valid/degraded/timeout
// flag vectors. Readings survive a flag clear; only reset zeroes them.
module rosc_result_bank #(
    parameter int NUM_SENSORS = 4,
    parameter int CNT_W = 16,
    localparam int SEL_W = $clog2(NUM_SENSORS)
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [SEL_W-1:0]       wr_idx,
    input  logic [CNT_W-1:0]       wr_data,
    input  logic [CNT_W-1:0]       threshold,
    input  logic                   to_en,
    input  logic [SEL_W-1:0]       to_idx,
    input  logic [SEL_W-1:0]       rd_addr,
    output logic [CNT_W-1:0]       rd_data,
    output logic [NUM_SENSORS-1:0] valid,
    output logic [NUM_SENSORS-1:0] degraded,
    output logic [NUM_SENSORS-1:0] timeout
);

    logic [CNT_W-1:0] bank [NUM_SENSORS];

    // Capture readings and maintain the per-sensor flags
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                bank[i] <= '0;
            end
            valid    <= '0;
            degraded <= '0;
            timeout  <= '0;
        end else begin
            if (clear) begin
                valid    <= '0;
                degraded <= '0;
                timeout  <= '0;
            end
            if (wr_en) begin
                bank[wr_idx]     <= wr_data;
                valid[wr_idx]    <= 1'b1;
                degraded[wr_idx] <= (wr_data < threshold);
            end
            if (to_en) begin
                timeout[to_idx] <= 1'b1;
            end
        end
    end

    // Combinational read port; out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < NUM_SENSORS) begin
            rd_data = bank[rd_addr];
        end
    end

endmodule

// File: rtl/rosc_meas_scheduler.sv
// Sweeps a bank of ring-oscillator sensors one at a time in slow mode,
// captures each count and flags readings below threshold as degraded.
module rosc_meas_scheduler
    import rosc_sched_pkg::*;
#(
    parameter int NUM_SENSORS    = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_MARGIN = TIMEOUT_MARGIN_DEFAULT,
    localparam int SEL_W = $clog2(NUM_SENSORS)
) (
    input  logic                       Clk,
    input  logic                       Resetn,
    input  logic                       Enable,
    input  logic                       Start,
    input  logic                       AutoMode,
    input  logic [NUM_SENSORS-1:0]     SensorMask,
    input  logic [3:0]                 NumClkCycles,
    input  logic [CNT_W-1:0]           Threshold,
    output logic [2*NUM_SENSORS-1:0]   RoscMode,
    output logic [NUM_SENSORS-1:0]     RoscEnable,
    output logic [3:0]                 RoscPeriod,
    output logic [NUM_SENSORS-1:0]     RoscReadComplete,
    input  logic [CNT_W*NUM_SENSORS-1:0] RoscReading,
    input  logic [NUM_SENSORS-1:0]     RoscValReady,
    input  logic [SEL_W-1:0]           RdAddr,
    output logic [CNT_W-1:0]           RdData,
    output logic [NUM_SENSORS-1:0]     ResultValid,
    output logic [NUM_SENSORS-1:0]     Degraded,
    output logic [NUM_SENSORS-1:0]     TimeoutErr,
    output logic                       Busy,
    output logic                       SweepDone,
    output logic [7:0]                 SweepCount
);

    // idx must be able to hold NUM_SENSORS itself as the end-of-sweep marker
    localparam int IDX_W = $clog2(NUM_SENSORS + 1);

    sched_state_t             state;
    logic [IDX_W-1:0]         idx;
    logic [SEL_W-1:0]         sel;
    logic [NUM_SENSORS-1:0]   mask_q;
    logic [CNT_W-1:0]         thr_q;
    logic [7:0]               timer;
    logic [CNT_W-1:0]         cur_reading;
    logic                     start_sweep;
    logic                     bank_wr;
    logic                     bank_to;

    assign sel         = idx[SEL_W-1:0];
    assign cur_reading = RoscReading[sel*CNT_W +: CNT_W];

    // Sweep start (from idle or back-to-back) and bank write strobes
    always_comb begin
        start_sweep = Enable && (((state == IDLE) && (Start || AutoMode)) ||
                                 ((state == DONE) && AutoMode));
        bank_wr     = Enable && (state == CAPTURE);
        bank_to     = Enable && (state == WAIT) && !RoscValReady[sel] && (timer == '0);
    end

    // Scheduler FSM with registered sensor controls and status
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state            <= IDLE;
            idx              <= '0;
            mask_q           <= '0;
            thr_q            <= '0;
            timer            <= '0;
            RoscPeriod       <= '0;
            RoscMode         <= '0;
            RoscEnable       <= '0;
            RoscReadComplete <= '0;
            Busy             <= 1'b0;
            SweepDone        <= 1'b0;
            SweepCount       <= '0;
        end else begin
            SweepDone        <= 1'b0;
            RoscReadComplete <= '0;
            if (!Enable) begin
                state      <= IDLE;
                Busy       <= 1'b0;
                RoscMode   <= {NUM_SENSORS{ROSC_STOP}};
                RoscEnable <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_sweep) begin
                            mask_q     <= SensorMask;
                            RoscPeriod <= NumClkCycles;
                            thr_q      <= Threshold;
                            idx        <= '0;
                            Busy       <= 1'b1;
                            state      <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (idx == IDX_W'(NUM_SENSORS)) begin
                            SweepDone  <= 1'b1;
                            SweepCount <= SweepCount + 8'd1;
                            state      <= DONE;
                        end else if (!mask_q[sel]) begin
                            idx <= idx + 1'b1;
                        end else begin
                            RoscEnable[sel]       <= 1'b1;
                            RoscMode[sel*2 +: 2]  <= ROSC_SLOW;
                            state                 <= ARM;
                        end
                    end
                    ARM: begin
                        timer <= 8'(RoscPeriod) + 8'(TIMEOUT_MARGIN) + 8'd2;
                        state <= WAIT;
                    end
                    WAIT: begin
                        // a ready sensor is captured even if the timer just expired
                        if (RoscValReady[sel]) begin
                            RoscReadComplete[sel] <= 1'b1;
                            RoscMode              <= {NUM_SENSORS{ROSC_STOP}};
                            state                 <= CAPTURE;
                        end else if (timer == '0) begin
                            RoscMode   <= {NUM_SENSORS{ROSC_STOP}};
                            RoscEnable <= '0;
                            state      <= RELEASE;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                    CAPTURE: begin
                        RoscEnable <= '0;
                        state      <= RELEASE;
                    end
                    RELEASE: begin
                        idx   <= idx + 1'b1;
                        state <= SELECT;
                    end
                    DONE: begin
                        if (start_sweep) begin
                            mask_q     <= SensorMask;
                            RoscPeriod <= NumClkCycles;
                            thr_q      <= Threshold;
                            idx        <= '0;
                            state      <= SELECT;
                        end else begin
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    rosc_result_bank #(
        .NUM_SENSORS (NUM_SENSORS),
        .CNT_W       (CNT_W)
    ) u_bank (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .clear     (start_sweep),
        .wr_en     (bank_wr),
        .wr_idx    (sel),
        .wr_data   (cur_reading),
        .threshold (thr_q),
        .to_en     (bank_to),
        .to_idx    (sel),
        .rd_addr   (RdAddr),
        .rd_data   (RdData),
        .valid     (ResultValid),
        .degraded  (Degraded),
        .timeout   (TimeoutErr)
    );

endmodule
